// File: rtl/counter_pkg.sv
// Shared definitions for the up/down counter datapath: FSM state encoding and default width.
package counter_pkg;

    localparam int unsigned COUNTER_W_DEFAULT = 4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/borrow_lookahead_decrementer.sv
// Combinational A - 1 (mod 2^WIDTH); each bit's borrow is a flat NOR of all lower bits,
// mirroring the lookahead incrementer rather than rippling.
module borrow_lookahead_decrementer
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = COUNTER_W_DEFAULT
) (
    input  logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] out
);

    assign out[0] = ~A[0];

    for (genvar i = 1; i < WIDTH; i++) begin : g_bit
        assign out[i] = A[i] ^ ~(|A[i-1:0]);
    end

endmodule

// File: rtl/down_timer.sv
// Loadable, pausable down-counter/timer with one-cycle done pulse on terminal count.
// Optional build macro DOWN_TIMER_AUTO_RELOAD_EN: terminal step reloads and keeps running.
module down_timer
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = COUNTER_W_DEFAULT
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic             enable,
    input  logic             stop,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

`ifdef DOWN_TIMER_AUTO_RELOAD_EN
    localparam bit AUTO_RELOAD = 1'b1;
`else
    localparam bit AUTO_RELOAD = 1'b0;
`endif

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] count_dec;
    logic             at_one;
    logic             reload_ok;

    borrow_lookahead_decrementer #(
        .WIDTH (WIDTH)
    ) u_dec (
        .A   (count_q),
        .out (count_dec)
    );

    assign at_one    = (count_q == WIDTH'(1));
    assign reload_ok = AUTO_RELOAD && (reload_q != '0);

    // Next-state: load > stop > start > decrement
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        done_d   = 1'b0;

        if (load) begin
            count_d  = load_value;
            reload_d = load_value;
            state_d  = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!stop && start) begin
                        if (count_q != '0) begin
                            state_d = ST_RUN;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state_d = ST_IDLE;
                    end else if (enable) begin
                        count_d = count_dec;
                        if (at_one) begin
                            done_d = 1'b1;
                            if (reload_ok) begin
                                count_d = reload_q;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        busy_d = (state_d == ST_RUN);
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign count = count_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule
